// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and legality definitions for the alu_seq execute stage.
// ALU_SEQ_MUL_EN selects whether opcode 11 (MUL) is a legal operation.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_ROL  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SLBI = 4'd8;
    localparam logic [3:0] OP_BTR  = 4'd9;
    localparam logic [3:0] OP_SUB  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
        return op <= OP_MUL;
`else
        return op < OP_MUL;
`endif
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Combinational WIDTH-bit barrel shifter: rotate or logical shift, left or right.
module alu_seq_shifter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [CNTW-1:0]  cnt,
    input  logic             left,
    input  logic             rotate,
    output logic [WIDTH-1:0] res
);

    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;

    // Shifting a doubled copy yields the rotation in one half with no wrap logic.
    assign dbl_l = {data, data} << cnt;
    assign dbl_r = {data, data} >> cnt;

    always_comb begin
        res = '0;
        if (left) begin
            res = rotate ? dbl_l[2*WIDTH-1:WIDTH] : (data << cnt);
        end else begin
            res = rotate ? dbl_r[WIDTH-1:0] : (data >> cnt);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with registered result and optional iterative multiply.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier; otherwise op 11 is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ofl,
    output logic             err
);

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ofl_q;
    logic             err_q;

    logic slot_free;
    logic accept;
    logic start_mul;

    assign slot_free = ~out_valid_q | out_ready;
    assign in_ready  = (state_q == ST_IDLE) & slot_free;
    assign accept    = in_valid & in_ready;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign ofl       = ofl_q;
    assign err       = err_q;

    // Shared adder: SUB is a + ~b + 1 with the external carry-in ignored.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             carry_msb;

    assign is_sub    = (op == OP_SUB);
    assign b_eff     = is_sub ? ~b : b;
    assign add_cin   = is_sub ? 1'b1 : cin;
    assign sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_cin};
    assign carry_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];

    logic [WIDTH-1:0] sh_res;

    alu_seq_shifter #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_shifter (
        .data   (a),
        .cnt    (b[CNTW-1:0]),
        .left   (~op[1]),
        .rotate (~op[0]),
        .res    (sh_res)
    );

    logic [WIDTH-1:0] btr;

    always_comb begin
        btr = '0;
        for (int i = 0; i < WIDTH; i++) begin
            btr[i] = a[WIDTH-1-i];
        end
    end

    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ofl;
    logic             alu_err;

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ofl  = 1'b0;
        alu_err  = 1'b0;
        if (!is_legal_op(op)) begin
            alu_err = 1'b1;
        end else begin
            case (op)
                OP_ADD, OP_SUB: begin
                    alu_res  = sum[WIDTH-1:0];
                    alu_cout = sum[WIDTH];
                    alu_ofl  = carry_msb ^ sum[WIDTH];
                end
                OP_OR:   alu_res = a | b;
                OP_XOR:  alu_res = a ^ b;
                OP_AND:  alu_res = a & b;
                OP_ROL, OP_SLL, OP_ROR, OP_SRL: alu_res = sh_res;
                OP_SLBI: alu_res = {a[WIDTH/2-1:0], b[WIDTH/2-1:0]};
                OP_BTR:  alu_res = btr;
                default: alu_res = '0;
            endcase
        end
    end

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] prod_q;
    logic [CNTW-1:0]  cnt_q;
    logic             mul_done_q;
    logic [WIDTH-1:0] prod_step;
    logic [WIDTH-1:0] prod_final;
    logic             last_iter;
    logic             mul_finish;

    assign start_mul  = (op == OP_MUL);
    assign prod_step  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    // Once the last iteration has run while stalled, prod_q already holds the product.
    assign prod_final = mul_done_q ? prod_q : prod_step;
    assign last_iter  = mul_done_q | (cnt_q == CNTW'(WIDTH - 1));
    assign mul_finish = (state_q == ST_MUL) & last_iter & slot_free;
`else
    assign start_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ofl_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            mul_done_q  <= 1'b0;
`endif
        end else begin
            if (accept && !start_mul) begin
                result_q    <= alu_res;
                cout_q      <= alu_cout;
                ofl_q       <= alu_ofl;
                err_q       <= alu_err;
                out_valid_q <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            end else if (mul_finish) begin
                result_q    <= prod_final;
                cout_q      <= 1'b0;
                ofl_q       <= 1'b0;
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
`endif
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

`ifdef ALU_SEQ_MUL_EN
            case (state_q)
                ST_IDLE: begin
                    if (accept && start_mul) begin
                        state_q    <= ST_MUL;
                        mcand_q    <= a;
                        mplier_q   <= b;
                        prod_q     <= '0;
                        cnt_q      <= '0;
                        mul_done_q <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (!mul_done_q) begin
                        prod_q   <= prod_step;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        if (cnt_q == CNTW'(WIDTH - 1)) begin
                            mul_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNTW'(1);
                        end
                    end
                    if (mul_finish) begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= '0;
                        mul_done_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
`else
            state_q <= ST_IDLE;
`endif
        end
    end

endmodule
